// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the intersection signal controller
//
// Purpose : phase enumeration, path index type, default phase lengths and
//           the round-robin successor helper used by traffic_simulation.
// Ports   : none (package).
package traffic_pkg;

  typedef enum logic {
    GO_MODE      = 1'b0,
    CAUTION_MODE = 1'b1
  } time_mode_t;

  typedef logic [1:0] path_t;

  localparam int NUM_PATHS              = 4;
  localparam int DEFAULT_GO_CYCLES      = 8;
  localparam int DEFAULT_CAUTION_CYCLES = 3;

  // Round-robin successor; the 2-bit add wraps 3 back to 0 naturally.
  function automatic path_t next_rr_path(input path_t p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/traffic_priority_pick.sv
// rtl/traffic_priority_pick.sv - lowest-index-first emergency request picker
//
// Purpose : combinational priority encoder over the four emergency requests.
// Ports   : req   [3:0] in  - one request bit per approach path
//           idx   [1:0] out - index of the lowest set request bit (0 if none)
//           valid       out - at least one request bit is set
module traffic_priority_pick
  import traffic_pkg::*;
(
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       valid
);

  always_comb begin
    valid = |req;
    idx   = 2'd0;
    if (req[0]) begin
      idx = 2'd0;
    end else if (req[1]) begin
      idx = 2'd1;
    end else if (req[2]) begin
      idx = 2'd2;
    end else if (req[3]) begin
      idx = 2'd3;
    end
  end

endmodule

// File: rtl/traffic_simulation.sv
// rtl/traffic_simulation.sv - four-way intersection GO/CAUTION controller with emergency preemption
//
// Purpose : grants right of way to one of four paths at a time, cycling each
//           grant through GO then CAUTION; emergency requests hold or preempt
//           the round-robin rotation.
// Ports   : clk                    in  - single clock, rising edge
//           reset                  in  - synchronous, active-low
//           emergency         [3:0] in  - level emergency request per path
//           current_free_path [1:0] out - registered index of path holding right of way
module traffic_simulation
  import traffic_pkg::*;
#(
  parameter int GO_CYCLES      = DEFAULT_GO_CYCLES,
  parameter int CAUTION_CYCLES = DEFAULT_CAUTION_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] emergency,
  output logic [1:0] current_free_path
);

  localparam int MAX_LEN = (GO_CYCLES > CAUTION_CYCLES) ? GO_CYCLES : CAUTION_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LEN);

  localparam logic [CNT_W-1:0] GO_LAST      = CNT_W'(GO_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAUTION_LAST = CNT_W'(CAUTION_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  time_mode_t       time_mode;
  time_mode_t       time_mode_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  path_t            path_nxt;

  logic [3:0]       cur_mask;
  logic             cur_req;
  logic             other_req;
  logic [1:0]       pick_idx;
  logic             pick_valid;

  // Split the request vector into "our own path" and "somebody else":
  // our own request extends GO, anybody else's cuts GO short.
  assign cur_mask  = 4'b0001 << current_free_path;
  assign cur_req   = |(emergency & cur_mask);
  assign other_req = |(emergency & ~cur_mask);

  traffic_priority_pick u_pick (
    .req   (emergency),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      time_mode         <= GO_MODE;
      cnt               <= '0;
      current_free_path <= 2'd0;
    end else begin
      time_mode         <= time_mode_nxt;
      cnt               <= cnt_nxt;
      current_free_path <= path_nxt;
    end
  end

  always_comb begin
    time_mode_nxt = time_mode;
    cnt_nxt       = cnt;
    path_nxt      = current_free_path;

    case (time_mode)
      GO_MODE: begin
        if (cur_req) begin
          // Own emergency wins over everything: freeze the GO count.
          cnt_nxt = cnt;
        end else if (other_req || (cnt == GO_LAST)) begin
          time_mode_nxt = CAUTION_MODE;
          cnt_nxt       = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      CAUTION_MODE: begin
        // CAUTION always runs to completion; requests only matter on its
        // final cycle, where they choose who gets the next GO.
        if (cnt == CAUTION_LAST) begin
          time_mode_nxt = GO_MODE;
          cnt_nxt       = '0;
          path_nxt      = pick_valid ? pick_idx : next_rr_path(current_free_path);
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        time_mode_nxt = GO_MODE;
        cnt_nxt       = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_simulation.sv
// tb/tb_traffic_simulation.sv - self-checking bench for traffic_simulation
module tb_traffic_simulation;

  localparam int GO_C  = 8;
  localparam int CAU_C = 3;

  logic       clk;
  logic       reset;
  logic [3:0] emergency;
  logic [1:0] current_free_path;

  int checks;
  int errors;

  // Reference state: which path holds the grant, whether it is in its
  // CAUTION phase, and how many more edges the current phase lasts.
  int m_path;
  bit m_caution;
  int m_left;

  traffic_simulation #(
    .GO_CYCLES      (GO_C),
    .CAUTION_CYCLES (CAU_C)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .emergency         (emergency),
    .current_free_path (current_free_path)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst_n, input logic [3:0] em);
    logic [3:0] others;
    if (!rst_n) begin
      m_path    = 0;
      m_caution = 0;
      m_left    = GO_C;
    end else if (!m_caution) begin
      others         = em;
      others[m_path] = 1'b0;
      if (em[m_path]) begin
        m_left = m_left;
      end else if (others != 4'd0 || m_left == 1) begin
        m_caution = 1;
        m_left    = CAU_C;
      end else begin
        m_left = m_left - 1;
      end
    end else begin
      if (m_left == 1) begin
        m_path    = (em != 4'd0) ? lowest_set(em) : (m_path + 1) % 4;
        m_caution = 0;
        m_left    = GO_C;
      end else begin
        m_left = m_left - 1;
      end
    end
  endtask

  task automatic tick(input logic rst_n, input logic [3:0] em);
    @(negedge clk);
    reset     = rst_n;
    emergency = em;
    @(posedge clk);
    #1;
    model_step(rst_n, em);
    check_eq("model_path", 32'(current_free_path), 32'(m_path));
    check_eq("model_mode", 32'(dut.time_mode), 32'(m_caution));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 4'd0);
  endtask

  initial begin
    int hold;
    logic [3:0] em_r;
    logic rst_r;

    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    emergency = 4'd0;
    m_path    = 0;
    m_caution = 0;
    m_left    = GO_C;

    // Reset, then idle rotation through all four paths.
    for (int i = 0; i < 3; i++) tick(1'b0, 4'd0);
    check_eq("rst_path", 32'(current_free_path), 0);
    check_eq("rst_mode", 32'(dut.time_mode), 0);
    check_eq("rst_cnt", 32'(dut.cnt), 0);
    idle(7);
    check_eq("idle_go7_mode", 32'(dut.time_mode), 0);
    idle(1);
    check_eq("idle_cau_mode", 32'(dut.time_mode), 1);
    check_eq("idle_cau_path", 32'(current_free_path), 0);
    idle(3);
    check_eq("idle_p1_path", 32'(current_free_path), 1);
    check_eq("idle_p1_mode", 32'(dut.time_mode), 0);
    idle(32);
    check_eq("idle_p3_cau", 32'(dut.time_mode), 1);
    check_eq("idle_p3_path", 32'(current_free_path), 3);
    idle(1);
    check_eq("wrap_path", 32'(current_free_path), 0);
    check_eq("wrap_mode", 32'(dut.time_mode), 0);

    // Preemption from path 0 at cnt=2 by path 2.
    idle(2);
    tick(1'b1, 4'b0100);
    check_eq("pre_cau_mode", 32'(dut.time_mode), 1);
    check_eq("pre_cau_path", 32'(current_free_path), 0);
    tick(1'b1, 4'b0100);
    tick(1'b1, 4'b0100);
    check_eq("pre_still_cau", 32'(dut.time_mode), 1);
    tick(1'b1, 4'b0100);
    check_eq("pre_go_path", 32'(current_free_path), 2);
    check_eq("pre_go_mode", 32'(dut.time_mode), 0);
    idle(1);

    // Current path holds GO while its own bit is high.
    tick(1'b0, 4'd0);
    idle(11);
    check_eq("hold_start_path", 32'(current_free_path), 1);
    idle(3);
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 4'b0011);
      check_eq("hold_go", {30'd0, current_free_path, 1'b0} | 32'(dut.time_mode), 32'd2);
    end
    idle(4);
    check_eq("hold_rem_go", 32'(dut.time_mode), 0);
    idle(1);
    check_eq("hold_rem_cau", 32'(dut.time_mode), 1);
    idle(3);
    check_eq("hold_next_path", 32'(current_free_path), 2);

    // Simultaneous requests: lowest index first, then the other one.
    tick(1'b0, 4'd0);
    idle(1);
    tick(1'b1, 4'b1010);
    check_eq("sim_cau", 32'(dut.time_mode), 1);
    tick(1'b1, 4'b1010);
    tick(1'b1, 4'b1010);
    tick(1'b1, 4'b1010);
    check_eq("sim_first", 32'(current_free_path), 1);
    tick(1'b1, 4'b1000);
    check_eq("sim_pre_cau", 32'(dut.time_mode), 1);
    check_eq("sim_pre_path", 32'(current_free_path), 1);
    tick(1'b1, 4'b1000);
    tick(1'b1, 4'b1000);
    tick(1'b1, 4'b1000);
    check_eq("sim_second", 32'(current_free_path), 3);
    idle(1);

    // Request raised only during CAUTION.
    tick(1'b0, 4'd0);
    idle(8);
    check_eq("cau_req_enter", 32'(dut.time_mode), 1);
    idle(1);
    tick(1'b1, 4'b1000);
    check_eq("cau_not_short", 32'(dut.time_mode), 1);
    tick(1'b1, 4'b1000);
    check_eq("cau_req_path", 32'(current_free_path), 3);
    check_eq("cau_req_go", 32'(dut.time_mode), 0);

    // Reset in the middle of CAUTION on path 2.
    tick(1'b0, 4'd0);
    idle(30);
    check_eq("mid_rst_path2", 32'(current_free_path), 2);
    check_eq("mid_rst_cau", 32'(dut.time_mode), 1);
    idle(1);
    tick(1'b0, 4'd0);
    check_eq("mid_rst_path", 32'(current_free_path), 0);
    check_eq("mid_rst_mode", 32'(dut.time_mode), 0);
    check_eq("mid_rst_cnt", 32'(dut.cnt), 0);

    // Randomized requests held for random spans, with rare resets.
    for (int n = 0; n < 300; n++) begin
      em_r = 4'd0;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) em_r[b] = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) em_r = 4'd0;
      hold = $urandom_range(1, 14);
      for (int k = 0; k < hold; k++) begin
        rst_r = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        tick(rst_r, em_r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
